// File: rtl/reg_write_feeder_if.sv
// rtl/reg_write_feeder_if.sv - producer valid/ready channel into the register write feeder
//
// Purpose: one producer channel. The producer drives valid/data and the
//          feeder answers with ready in the same cycle.
// Signals:
//   valid - producer offers data this cycle
//   data  - producer word, DATA_WIDTH bits
//   ready - feeder accepts the word at the next rising edge
// Modports:
//   master - producer side (drives valid/data)
//   slave  - feeder side (drives ready)
interface reg_write_feeder_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  valid;
  logic [DATA_WIDTH-1:0] data;
  logic                  ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/reg_write_feeder.sv
// rtl/reg_write_feeder.sv - round-robin arbitrated FIFO feeding a register write port
//
// Purpose: two producers compete for a DEPTH-entry FIFO through a
//          round-robin arbiter; the FIFO drains one word per cycle into the
//          register write port whenever drain_en allows it.
// Ports:
//   clk      - single clock, rising edge
//   reset    - asynchronous active-low reset
//   src0     - producer 0 channel (slave side)
//   src1     - producer 1 channel (slave side)
//   drain_en - downstream permits a register write this cycle
//   write_en - registered register write enable
//   data_out - registered register write data
//   count    - FIFO occupancy
//   full     - count == DEPTH
//   empty    - count == 0
module reg_write_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  reg_write_feeder_if.slave            src0,
  reg_write_feeder_if.slave            src1,
  input  logic                         drain_en,
  output logic                         write_en,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  generate
    if (DATA_WIDTH < 8 || DATA_WIDTH > 32 || DEPTH < 2 || DEPTH > 16 ||
        (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
      $error("reg_write_feeder: DATA_WIDTH must be 8..32 and DEPTH a power of two in 2..16");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  rr;        // 0: src0 wins a tie, 1: src1 wins a tie
  logic                  grant0;
  logic                  grant1;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] push_data;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Grants are gated by reset so nothing can complete while it is held low.
  // A full FIFO refuses both sources even if a pop happens this cycle.
  always_comb begin
    grant0    = 1'b0;
    grant1    = 1'b0;
    push_data = src0.data;
    if (reset && !full) begin
      grant0 = src0.valid && (!src1.valid || !rr);
      grant1 = src1.valid && (!src0.valid ||  rr);
    end
    if (grant1) begin
      push_data = src1.data;
    end
  end

  assign src0.ready = grant0;
  assign src1.ready = grant1;
  assign push       = grant0 || grant1;
  assign pop        = drain_en && !empty;

  // Storage needs no reset: stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rr       <= 1'b0;
      write_en <= 1'b0;
      data_out <= '0;
    end else begin
      write_en <= pop;
      if (pop) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;   // DEPTH is a power of two, so this wraps
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Only a contested transfer moves the pointer, to the loser.
      if (push && src0.valid && src1.valid) begin
        rr <= grant0;
      end
    end
  end

endmodule

// File: tb/tb_reg_write_feeder.sv
// tb/tb_reg_write_feeder.sv - directed self-checking bench for reg_write_feeder
module tb_reg_write_feeder;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          drain_en = 1'b0;
  logic          write_en;
  logic [DW-1:0] data_out;
  logic [2:0]    count;
  logic          full;
  logic          empty;

  int compares = 0;
  int fails    = 0;

  reg_write_feeder_if #(.DATA_WIDTH(DW)) s0 ();
  reg_write_feeder_if #(.DATA_WIDTH(DW)) s1 ();

  always #5 clk = ~clk;

  reg_write_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .src0     (s0),
    .src1     (s1),
    .drain_en (drain_en),
    .write_en (write_en),
    .data_out (data_out),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int tx;
    int rx;
    logic acc;

    s0.valid = 1'b0; s0.data = '0;
    s1.valid = 1'b0; s1.data = '0;

    // Reset state, with a producer trying to get in
    tick();
    s0.valid = 1'b1; s0.data = 32'hEE;
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_we", write_en, 0);
    chk("rst_data", data_out, 0);
    chk("rst_s0_ready", s0.ready, 0);
    tick();
    chk("rst_count_hold", count, 0);
    s0.valid = 1'b0;
    reset = 1'b1;
    tick();

    // Single source, empty FIFO: 2-cycle latency
    drain_en = 1'b1;
    s0.valid = 1'b1; s0.data = 32'hA5;
    #1;
    chk("single_ready", s0.ready, 1);
    tick();
    s0.valid = 1'b0;
    #1;
    chk("single_c1_count", count, 1);
    chk("single_c1_we", write_en, 0);
    tick();
    chk("single_c2_we", write_en, 1);
    chk("single_c2_data", data_out, 32'hA5);
    chk("single_c2_count", count, 0);
    tick();
    chk("single_c3_we", write_en, 0);
    chk("single_c3_hold", data_out, 32'hA5);

    // Contention with drain off: src0,src1,src0,src1 then full
    drain_en = 1'b0;
    s0.valid = 1'b1; s0.data = 32'h11;
    s1.valid = 1'b1; s1.data = 32'h21;
    #1;
    chk("arb1_s0", s0.ready, 1);
    chk("arb1_s1", s1.ready, 0);
    tick();
    s0.data = 32'h12;
    #1;
    chk("arb2_s0", s0.ready, 0);
    chk("arb2_s1", s1.ready, 1);
    tick();
    s1.data = 32'h22;
    #1;
    chk("arb3_s0", s0.ready, 1);
    chk("arb3_s1", s1.ready, 0);
    tick();
    s0.valid = 1'b0;
    #1;
    chk("arb4_s1", s1.ready, 1);
    chk("arb4_count", count, 3);
    tick();

    // Full boundary: src1 refused, also while a pop happens
    s1.data = 32'h23;
    #1;
    chk("full_flag", full, 1);
    chk("full_count", count, 4);
    chk("full_s1_ready", s1.ready, 0);
    tick();
    drain_en = 1'b1;
    #1;
    chk("full_pop_s1_ready", s1.ready, 0);
    tick();
    chk("drain1_we", write_en, 1);
    chk("drain1_data", data_out, 32'h11);
    chk("drain1_count", count, 3);
    chk("drain1_s1_ready", s1.ready, 1);
    tick();
    s1.valid = 1'b0;
    #1;
    chk("drain2_data", data_out, 32'h21);
    chk("drain2_count", count, 3);
    tick();
    chk("drain3_data", data_out, 32'h12);
    chk("drain3_count", count, 2);
    tick();
    chk("drain4_data", data_out, 32'h22);
    tick();
    chk("drain5_we", write_en, 1);
    chk("drain5_data", data_out, 32'h23);
    chk("drain5_count", count, 0);
    tick();
    chk("drain6_we", write_en, 0);
    chk("drain6_empty", empty, 1);
    drain_en = 1'b0;

    // Asynchronous reset mid-stream with count=3
    s0.valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s0.data = 32'h31 + 32'(i);
      tick();
    end
    s0.valid = 1'b0;
    drain_en = 1'b1;
    #1;
    chk("mid_full_count", count, 4);
    tick();
    drain_en = 1'b0;
    #1;
    chk("mid_we", write_en, 1);
    chk("mid_data", data_out, 32'h31);
    chk("mid_count", count, 3);
    #2;
    reset = 1'b0;
    #1;
    chk("async_count", count, 0);
    chk("async_empty", empty, 1);
    chk("async_full", full, 0);
    chk("async_we", write_en, 0);
    chk("async_data", data_out, 0);
    s1.valid = 1'b1; s1.data = 32'h55;
    #1;
    chk("async_s1_ready", s1.ready, 0);
    tick();
    chk("async_count_hold", count, 0);
    s1.valid = 1'b0;
    reset = 1'b1;
    drain_en = 1'b1;
    tick();
    tick();
    chk("post_rst_we", write_en, 0);
    chk("post_rst_empty", empty, 1);

    // Wrap-around stream with drain toggling
    tx = 0;
    rx = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      s0.valid = (tx < 10);
      s0.data  = 32'h1000_0000 + 32'(tx);
      drain_en = ((cyc % 2) == 0);
      #1;
      acc = s0.valid && s0.ready;
      chk("wrap_count_le4", (count <= 3'd4), 1);
      if (write_en) begin
        chk("wrap_data", data_out, 32'h1000_0000 + 32'(rx));
        rx++;
      end
      tick();
      if (acc) tx++;
    end
    s0.valid = 1'b0;
    chk("wrap_tx", tx, 10);
    chk("wrap_rx", rx, 10);
    chk("wrap_empty", empty, 1);

    // Push+pop steady state at count=2
    drain_en = 1'b0;
    s0.valid = 1'b1;
    s0.data = 32'h40;
    tick();
    s0.data = 32'h41;
    tick();
    for (int k = 0; k < 6; k++) begin
      s0.data = 32'h42 + 32'(k);
      drain_en = 1'b1;
      #1;
      chk("steady_count", count, 2);
      chk("steady_ready", s0.ready, 1);
      if (k >= 1) begin
        chk("steady_we", write_en, 1);
        chk("steady_data", data_out, 32'h40 + 32'(k - 1));
      end
      tick();
    end
    s0.valid = 1'b0;
    #1;
    chk("steady_last_we", write_en, 1);
    chk("steady_last_data", data_out, 32'h45);
    chk("steady_last_count", count, 2);
    tick();
    tick();
    tick();
    chk("steady_drained", empty, 1);
    drain_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule

// File: doc/reg_write_feeder.md
Name: reg_write_feeder

Overview:
- Upstream stage of the custom processor register. Feeds that register's write port (write_en / data_in).
- Two producers (e.g. ALU write-back and load unit) each offer data through a valid/ready handshake.
- A round-robin arbiter grants one producer per cycle and pushes the granted word into a DEPTH-entry FIFO.
- The FIFO drains at most one word per cycle to the register when the downstream allows it.

Parameters:
- DATA_WIDTH, 8, data word width; legal range 8..32.
- DEPTH, 4, FIFO entries; power of two, legal range 2..16.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- src0_valid  input  1  producer 0 offers src0_data.
- src0_data  input  DATA_WIDTH  producer 0 word.
- src0_ready  output  1  producer 0 word accepted this cycle (combinational).
- src1_valid  input  1  producer 1 offers src1_data.
- src1_data  input  DATA_WIDTH  producer 1 word.
- src1_ready  output  1  producer 1 word accepted this cycle (combinational).
- drain_en  input  1  downstream permits a register write this cycle.
- write_en  output  1  registered; drives the register write enable.
- data_out  output  DATA_WIDTH  registered; drives the register data_in.
- count  output  $clog2(DEPTH+1)  current FIFO occupancy.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO pointers and count = 0; empty=1, full=0.
  - write_en=0, data_out=0.
  - Round-robin pointer = 0 (src0 has priority).
  - No handshake completes while reset is low.
  - Words held in the FIFO are discarded.
- Handshake:
  - A transfer occurs on srcN when srcN_valid && srcN_ready at a rising edge.
  - A producer holds valid/data stable until ready. Ready never depends on the producer's own data.
- Arbitration (combinational, full==0 required for any grant):
  - Only one valid: that source is ready.
  - Both valid: the source indicated by the rr pointer is ready; the other sees ready=0.
  - After a granted transfer with both valid, the rr pointer moves to the non-granted source.
  - rr pointer unchanged when only one source was valid or no transfer occurred.
  - full==1: src0_ready = src1_ready = 0. No push while full, even if a pop occurs the same cycle.
- Push: the granted word is written at the write pointer. Write pointer increments modulo DEPTH (wrap-around).
- Pop, when drain_en && !empty at a rising edge:
  - Next cycle: write_en=1 and data_out = head word.
  - Read pointer increments modulo DEPTH.
- No pop: write_en=0 next cycle and data_out holds its last value.
- Simultaneous push and pop (not full, not empty): count unchanged; both pointers advance.
- Pop from a 1-entry FIFO with a simultaneous push: legal. The new word becomes the head for the next cycle.
- Empty FIFO: a word pushed in cycle N is popped at the earliest edge N+1, giving write_en=1 in cycle N+2. Minimum input-to-write latency is 2 cycles; there is no bypass path.
- count: updates at the same edge as push/pop; +1 on push only, -1 on pop only.
- Order: words leave in acceptance order; the two sources' interleaving equals grant order.
- Out of range: DATA_WIDTH outside 8..32, or DEPTH not a power of two in 2..16, is an elaboration error. Enforce with a generate-time check.

Test Plan:
- Reset: assert reset=0 mid-stream with count=3 -> count=0, empty=1, write_en=0, data_out=0 asynchronously. Accept nothing until reset=1.
- Single source, empty FIFO, drain_en=1: src0 sends 8'hA5 in cycle 0 -> src0_ready=1 in cycle 0; write_en=1 with data_out=8'hA5 in cycle 2; count returns to 0.
- Contention, drain_en=0: both valid for 4 cycles with src0 0x11,0x12 and src1 0x21,0x22 -> grants src0,src1,src0,src1; full=1 after the 4th.
  - Then drain_en=1 -> write_en pulses output 0x11,0x21,0x12,0x22 in that order.
- Full boundary, DEPTH=4: FIFO full with src1_valid=1 -> src1_ready=0 for every cycle until count<4.
  - Simultaneous pop while full does not admit a push that cycle.
- Wrap-around, DATA_WIDTH=32: stream 10 words 0x1000_0000..0x1000_0009 with drain_en toggling 1,0,1,0 -> all 10 appear in order with no loss or duplication.
  - count never exceeds 4.
- Push+pop steady state: both pointers advance with count stable at 2 for 6 cycles -> one write_en per cycle, data in order.
